bcd_countdown_timer: RTL

//  2-digit BCD down-counter/timer, the countdown companion to the team's 2-digit BCD up-counter.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_dec.sv | 32 +++
 rtl/bcd_countdown_timer.sv | 108 ++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types for the 2-digit BCD up/down counters.
package bcd_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSED
   } state_t;

   // True when a digit holds a legal BCD value (0-9).
   function automatic logic bcd_valid(input bcd_t d);
      return (d <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of a down-counter: decrements when enabled and requested,
// wraps 0 -> 9 and signals a borrow to the next higher digit.
module bcd_digit_dec
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       en,
   input  logic       borrow_in,
   output logic [3:0] digit,
   output logic       borrow_out
);

   logic dec;

   assign dec        = en & borrow_in;
   assign borrow_out = (digit == 4'd0) && dec;

   // Digit register: load has priority over decrement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit <= '0;
      end else if (load) begin
         digit <= load_val;
      end else if (dec) begin
         digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
      end
   end

endmodule

// File: rtl/bcd_countdown_timer.sv
// 2-digit BCD countdown timer: preset load with validation, start/pause
// control, prescaled decrement and a one-cycle done pulse on reaching 00.
module bcd_countdown_timer
   import bcd_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_ones,
   input  logic [3:0] load_tens,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic       running,
   output logic       done,
   output logic       load_err
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   state_t        state, state_next;
   logic [PW-1:0] presc, presc_next;
   logic          tick, load_ok, done_next, load_err_next;
   logic          count_zero, count_one, ones_borrow;

   assign count_zero = (tens == 4'd0) && (ones == 4'd0);
   assign count_one  = (tens == 4'd0) && (ones == 4'd1);
   assign running    = (state == RUN);

   // State, prescaler and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         presc    <= '0;
         done     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         state    <= state_next;
         presc    <= presc_next;
         done     <= done_next;
         load_err <= load_err_next;
      end
   end

   // Control priority: load > start > pause > tick; any strobe consumes the cycle.
   always_comb begin
      state_next    = state;
      presc_next    = presc;
      tick          = 1'b0;
      load_ok       = 1'b0;
      done_next     = 1'b0;
      load_err_next = 1'b0;
      if (load) begin
         if (bcd_valid(load_tens) && bcd_valid(load_ones)) begin
            load_ok    = 1'b1;
            state_next = IDLE;
            presc_next = '0;
         end else begin
            load_err_next = 1'b1;
         end
      end else if (start && (state != RUN) && !count_zero) begin
         state_next = RUN;
         if (state == IDLE) begin
            presc_next = '0;
         end
      end else if (pause && (state == RUN)) begin
         state_next = PAUSED;
      end else if (state == RUN) begin
         if (presc == PRESC_LAST) begin
            presc_next = '0;
            tick       = 1'b1;
            if (count_one) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end else begin
            presc_next = presc + PW'(1);
         end
      end
   end

   bcd_digit_dec u_ones (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load_ok),
      .load_val   (load_ones),
      .en         (tick),
      .borrow_in  (1'b1),
      .digit      (ones),
      .borrow_out (ones_borrow)
   );

   bcd_digit_dec u_tens (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load_ok),
      .load_val   (load_tens),
      .en         (tick),
      .borrow_in  (ones_borrow),
      .digit      (tens),
      .borrow_out ()
   );

endmodule
